spi_msg_regfile: RTL

//  Byte-to-register message layer for the SPI slave, generalised in register width, register count and burst length.

---
 rtl/spi_msg_regfile.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_msg_regfile.sv
// Byte-to-register message layer for an SPI slave: command decode, RW/RO register access, bursts, snapshots.
// Optional status byte after each command enabled by defining SPI_MSG_STATUS_EN.
module spi_msg_regfile #(
    parameter int               REG_W   = 32,
    parameter int               NR_RW   = 4,
    parameter int               NR_RO   = 12,
    parameter logic [REG_W-1:0] RW_INIT = '0
) (
    input  logic                   sysClk,
    input  logic                   usrReset_n,
    input  logic                   frameAct,
    input  logic                   rxValid,
    input  logic [7:0]             rx,
    output logic [7:0]             tx,
    input  logic [NR_RO*REG_W-1:0] roRegs1D,
    output logic [NR_RW*REG_W-1:0] rwRegs1D,
    output logic                   wrStrobe,
    output logic [6:0]             wrAddr,
    output logic                   errAddr
);

    localparam int         NB      = REG_W / 8;
    localparam logic [2:0] BC_LAST = 3'(NB - 1);
    localparam logic [7:0] RW_LIM  = 8'(NR_RW);
    localparam logic [7:0] TOT_LIM = 8'(NR_RW + NR_RO);

    typedef enum logic {
        ST_CMD,
        ST_DATA
    } state_t;

    state_t                   state_q, state_d;
    logic                     dir_wr_q, dir_wr_d;
    logic [6:0]               addr_q, addr_d;
    logic [2:0]               bc_q, bc_d;
    logic [REG_W-1:0]         acc_q, acc_d;
    logic [REG_W-1:0]         txs_q, txs_d;
    logic [NR_RW*REG_W-1:0]   rw_q, rw_d;
    logic                     wr_strobe_q, wr_strobe_d;
    logic [6:0]               wr_addr_q, wr_addr_d;
    logic                     err_q, err_d;
    logic                     in_status;

    logic [6:0]               snap_addr;
    logic [REG_W-1:0]         snap_data;
    logic                     snap_oob;
    logic [REG_W+7:0]         acc_cat;
    logic [REG_W+7:0]         txs_cat;
    logic [REG_W-1:0]         acc_next;
    logic [REG_W-1:0]         txs_next;
    logic                     addr_in_rw;
    logic                     addr_oob;

    // The register to snapshot is the new command address or the next one in the burst.
    assign snap_addr  = (state_q == ST_CMD) ? rx[6:0] : addr_q + 7'd1;
    assign acc_cat    = {acc_q, rx};
    assign acc_next   = acc_cat[REG_W-1:0];
    assign txs_cat    = {txs_q, 8'h00};
    assign txs_next   = txs_cat[REG_W-1:0];
    assign addr_in_rw = ({1'b0, addr_q} < RW_LIM);
    assign addr_oob   = ({1'b0, addr_q} >= TOT_LIM);

    always_comb begin
        snap_data = '0;
        for (int k = 0; k < NR_RW; k++) begin
            if (snap_addr == 7'(k)) snap_data = rw_q[REG_W*k +: REG_W];
        end
        for (int k = 0; k < NR_RO; k++) begin
            if (snap_addr == 7'(NR_RW + k)) snap_data = roRegs1D[REG_W*k +: REG_W];
        end
        snap_oob = ({1'b0, snap_addr} >= TOT_LIM);
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
        state_d     = state_q;
        dir_wr_d    = dir_wr_q;
        addr_d      = addr_q;
        bc_d        = bc_q;
        acc_d       = acc_q;
        txs_d       = txs_q;
        rw_d        = rw_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        err_d       = err_q;

        if (!frameAct) begin
            // Frame end wins over a coincident byte; partial registers are dropped here.
            state_d = ST_CMD;
            bc_d    = '0;
            acc_d   = '0;
            txs_d   = '0;
        end else if (rxValid) begin
            unique case (state_q)
                ST_CMD: begin
                    dir_wr_d = rx[7];
                    addr_d   = rx[6:0];
                    bc_d     = '0;
                    acc_d    = '0;
                    state_d  = ST_DATA;
                    if (!rx[7]) begin
                        txs_d = snap_data;
                        if (snap_oob) err_d = 1'b1;
                    end else begin
                        txs_d = '0;
                    end
                end
                ST_DATA: begin
                    if (!in_status) begin
                        if (dir_wr_q) begin
                            acc_d = acc_next;
                            if (bc_q == BC_LAST) begin
                                acc_d = '0;
                                if (addr_q == 7'h7F) begin
                                    err_d = 1'b0;
                                end else if (addr_in_rw) begin
                                    for (int k = 0; k < NR_RW; k++) begin
                                        if (addr_q == 7'(k)) rw_d[REG_W*k +: REG_W] = acc_next;
                                    end
                                    wr_strobe_d = 1'b1;
                                    wr_addr_d   = addr_q;
                                end else if (addr_oob) begin
                                    err_d = 1'b1;
                                end
                            end
                        end else begin
                            txs_d = txs_next;
                            if (bc_q == BC_LAST) begin
                                txs_d = snap_data;
                                if (snap_oob) err_d = 1'b1;
                            end
                        end
                        if (bc_q == BC_LAST) begin
                            bc_d   = '0;
                            addr_d = addr_q + 7'd1;
                        end else begin
                            bc_d = bc_q + 3'd1;
                        end
                    end
                end
                default: state_d = ST_CMD;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the register file is small and is reset like any other flop.
    always_ff @(posedge sysClk or negedge usrReset_n) begin
        if (!usrReset_n) begin
            state_q     <= ST_CMD;
            dir_wr_q    <= 1'b0;
            addr_q      <= '0;
            bc_q        <= '0;
            acc_q       <= '0;
            txs_q       <= '0;
            rw_q        <= {NR_RW{RW_INIT}};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_wr_q    <= dir_wr_d;
            addr_q      <= addr_d;
            bc_q        <= bc_d;
            acc_q       <= acc_d;
            txs_q       <= txs_d;
            rw_q        <= rw_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            err_q       <= err_d;
        end
    end

`ifdef SPI_MSG_STATUS_EN
    logic       stat_pend_q, stat_pend_d;
    logic [7:0] stat_byte_q, stat_byte_d;
    logic [6:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        stat_pend_d = stat_pend_q;
        stat_byte_d = stat_byte_q;
        wr_cnt_d    = wr_cnt_q + {6'd0, wr_strobe_d};
        if (!frameAct) begin
            stat_pend_d = 1'b0;
        end else if (rxValid) begin
            if (state_q == ST_CMD) begin
                stat_pend_d = 1'b1;
                stat_byte_d = {err_d, wr_cnt_q};
            end else begin
                stat_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sysClk or negedge usrReset_n) begin
        if (!usrReset_n) begin
            stat_pend_q <= 1'b0;
            stat_byte_q <= '0;
            wr_cnt_q    <= '0;
        end else begin
            stat_pend_q <= stat_pend_d;
            stat_byte_q <= stat_byte_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    // The slot right after the command carries status; data follows one byte later.
    assign in_status = stat_pend_q;
    assign tx        = stat_pend_q ? stat_byte_q : txs_q[REG_W-1 -: 8];
`else
    assign in_status = 1'b0;
    assign tx        = txs_q[REG_W-1 -: 8];
`endif

    assign rwRegs1D = rw_q;
    assign wrStrobe = wr_strobe_q;
    assign wrAddr   = wr_addr_q;
    assign errAddr  = err_q;

endmodule
